// File: rtl/mips_pkg.sv
// Shared constants for the MIPS multicycle controller: opcodes, funct codes,
// ALU operation codes, ALU-decoder request codes and FSM state encodings.
package mips_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_sel_t;

    // What the FSM asks of the ALU decoder: a fixed add/sub, or follow funct.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control: maps the FSM's request and the funct field to alu_sel.
// o_funct_bad flags a funct outside the supported R-type set, independent of the request.
module mips_alu_decoder
    import mips_pkg::*;
(
    input  alu_op_t    i_alu_op,
    input  logic [5:0] i_funct,
    output alu_sel_t   o_alu_sel,
    output logic       o_funct_bad
);

    alu_sel_t w_funct_sel;

    always_comb begin
        w_funct_sel = ALU_ADD;
        o_funct_bad = 1'b0;
        case (i_funct)
            FN_ADD:  w_funct_sel = ALU_ADD;
            FN_SUB:  w_funct_sel = ALU_SUB;
            FN_AND:  w_funct_sel = ALU_AND;
            FN_OR:   w_funct_sel = ALU_OR;
            FN_SLT:  w_funct_sel = ALU_SLT;
            default: o_funct_bad = 1'b1;
        endcase
    end

    always_comb begin
        o_alu_sel = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB:   o_alu_sel = ALU_SUB;
            ALUOP_FUNCT: o_alu_sel = w_funct_sel;
            default:     o_alu_sel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM sequencing MIPS instructions through the multicycle datapath.
// Optional MIPS_CTRL_MEM_WAIT_EN adds mem_ready so memory states stall until the access completes.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
`ifdef MIPS_CTRL_MEM_WAIT_EN
    input  logic               mem_ready,
`endif
    output logic               pc_en,
    output logic               iord,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic [3:0]         alu_sel,
    output logic               illegal,
    output logic [STATE_W-1:0] dbg_state
);

    state_t   r_state;
    state_t   w_next;
    alu_op_t  w_alu_op;
    alu_sel_t w_alu_sel;
    logic     w_mem_ready;
    logic     w_pc_write;
    logic     w_branch;
    logic     w_ir_write;
    logic     w_mem_write;
    logic     w_reg_write;
    logic     w_illegal_op;
    logic     w_funct_bad;

`ifdef MIPS_CTRL_MEM_WAIT_EN
    assign w_mem_ready = mem_ready;
`else
    assign w_mem_ready = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = S_FETCH;
        w_alu_op     = ALUOP_ADD;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_illegal_op = 1'b0;
        iord         = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_RD2;
        pc_src       = PCSRC_ALU;
        case (r_state)
            S_FETCH: begin
                // Strobes fire only in the completing cycle so a stalled fetch loads once.
                w_ir_write = w_mem_ready;
                w_pc_write = w_mem_ready;
                alu_src_b  = SRCB_FOUR;
                w_next     = w_mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM2;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_next       = S_FETCH;
                        w_illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord   = 1'b1;
                w_next = w_mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWR: begin
                iord        = 1'b1;
                w_mem_write = w_mem_ready;
                w_next      = w_mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                w_alu_op  = ALUOP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                w_alu_op  = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                w_branch  = 1'b1;
                w_next    = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = PCSRC_JUMP;
                w_pc_write = 1'b1;
                w_next     = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    mips_alu_decoder u_alu_decoder (
        .i_alu_op    (w_alu_op),
        .i_funct     (funct),
        .o_alu_sel   (w_alu_sel),
        .o_funct_bad (w_funct_bad)
    );

    // Architectural-state writes are blocked while reset is held, whatever the state.
    assign pc_en     = ~reset & (w_pc_write | (w_branch & zero));
    assign ir_write  = ~reset & w_ir_write;
    assign reg_write = ~reset & w_reg_write;
    assign mem_write = ~reset & w_mem_write;
    assign alu_sel   = w_alu_sel;
    assign illegal   = w_illegal_op | ((r_state == S_EXEC) & w_funct_bad);
    assign dbg_state = STATE_W'(r_state);

endmodule
